// File: rtl/balance_cntrl_pipe.sv
// rtl/balance_cntrl_pipe.sv - PID balance controller with soft start, steering mix and pipelined outputs.
// Optional macro SPD_SLEW_EN limits each output step to +/-64 LSB.
module balance_cntrl_pipe #(
    parameter int SPD_W        = 12,
    parameter int PIPE_STG     = 2,
    parameter int FAST_SIM     = 0,
    parameter int TOO_FAST_LIM = 1536,
    parameter int TF_CNT       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld,
    input  logic signed [15:0]      ptch,
    input  logic signed [15:0]      ptch_rt,
    input  logic                    pwr_up,
    input  logic                    rider_off,
    input  logic        [11:0]      steer_pot,
    input  logic                    en_steer,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    too_fast,
    output logic                    out_vld
);
    localparam int SMAX = (1 << (SPD_W - 1)) - 1;
    localparam int SMIN = -(1 << (SPD_W - 1));
    localparam int ISH  = (FAST_SIM != 0) ? 2 : 6;

    function automatic logic signed [31:0] clip(input logic signed [31:0] v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    logic signed [17:0]      integ;
    logic signed [SPD_W-1:0] pid_cntrl;
    logic                    pid_vld;
    logic        [7:0]       prescaler;
    logic        [7:0]       ss_tmr;
    logic        [3:0]       tf_cnt;

    logic signed [9:0]       ptch_sat;
    logic signed [31:0]      p_term;
    logic signed [11:0]      i_term;
    logic signed [11:0]      d_term;

    always_comb begin
        ptch_sat = 10'(clip(32'(ptch), -512, 511));
        p_term   = 5 * 32'(ptch_sat);
        d_term   = 12'(clip(-(32'(ptch_rt) >>> 6), -2048, 2047));
        i_term   = 12'(clip(32'(integ) >>> ISH, -2048, 2047));
    end

    // PID sum uses the integrator value from before this sample's accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ     <= '0;
            pid_cntrl <= '0;
            pid_vld   <= 1'b0;
            prescaler <= '0;
            ss_tmr    <= '0;
        end else begin
            pid_vld <= vld;
            if (vld)
                pid_cntrl <= SPD_W'(clip(p_term + 32'(i_term) + 32'(d_term), SMIN, SMAX));
            if (rider_off || !pwr_up)
                integ <= '0;
            else if (vld)
                integ <= 18'(clip(32'(integ) + 32'(ptch_sat), -131072, 131071));
            if (!pwr_up) begin
                prescaler <= '0;
                ss_tmr    <= '0;
            end else begin
                prescaler <= prescaler + 8'd1;
                if (((FAST_SIM != 0) || (prescaler == 8'hFF)) && (ss_tmr != 8'hFF))
                    ss_tmr <= ss_tmr + 8'd1;
            end
        end
    end

    logic signed [31:0]      scaled;
    logic signed [31:0]      steer_offs;
    logic signed [SPD_W-1:0] math_l;
    logic signed [SPD_W-1:0] math_r;

    always_comb begin
        scaled     = (32'(pid_cntrl) * $signed({24'd0, ss_tmr})) >>> 8;
        steer_offs = ($signed({20'd0, steer_pot}) - 32'sd2047) >>> 3;
        if (!pwr_up) begin
            math_l = '0;
            math_r = '0;
        end else if (en_steer) begin
            math_l = SPD_W'(clip(scaled + steer_offs, SMIN, SMAX));
            math_r = SPD_W'(clip(scaled - steer_offs, SMIN, SMAX));
        end else begin
            math_l = SPD_W'(scaled);
            math_r = SPD_W'(scaled);
        end
    end

    logic signed [SPD_W-1:0] pre_l;
    logic signed [SPD_W-1:0] pre_r;
    logic                    pre_v;

    // Stages ahead of the final output register; the final stage is always present.
    generate
        if (PIPE_STG == 1) begin : g_nopipe
            assign pre_l = math_l;
            assign pre_r = math_r;
            assign pre_v = pid_vld;
        end else begin : g_pipe
            logic signed [SPD_W-1:0] dl [PIPE_STG-1];
            logic signed [SPD_W-1:0] dr [PIPE_STG-1];
            logic                    dv [PIPE_STG-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_STG - 1; i++) begin
                        dl[i] <= '0;
                        dr[i] <= '0;
                        dv[i] <= 1'b0;
                    end
                end else begin
                    dl[0] <= math_l;
                    dr[0] <= math_r;
                    dv[0] <= pid_vld;
                    for (int i = 1; i < PIPE_STG - 1; i++) begin
                        dl[i] <= dl[i-1];
                        dr[i] <= dr[i-1];
                        dv[i] <= dv[i-1];
                    end
                end
            end
            assign pre_l = dl[PIPE_STG-2];
            assign pre_r = dr[PIPE_STG-2];
            assign pre_v = dv[PIPE_STG-2];
        end
    endgenerate

`ifdef SPD_SLEW_EN
    function automatic logic signed [SPD_W-1:0] slew(input logic signed [SPD_W-1:0] tgt,
                                                     input logic signed [SPD_W-1:0] prev);
        logic signed [31:0] d;
        d = 32'(tgt) - 32'(prev);
        if (d > 64) return prev + SPD_W'(64);
        if (d < -64) return prev - SPD_W'(64);
        return tgt;
    endfunction
`endif

    logic signed [SPD_W-1:0] fin_l;
    logic signed [SPD_W-1:0] fin_r;
    logic                    over;

    always_comb begin
`ifdef SPD_SLEW_EN
        fin_l = pwr_up ? slew(pre_l, lft_spd) : pre_l;
        fin_r = pwr_up ? slew(pre_r, rght_spd) : pre_r;
`else
        fin_l = pre_l;
        fin_r = pre_r;
`endif
        over = (((fin_l < 0) ? -32'(fin_l) : 32'(fin_l)) > TOO_FAST_LIM) ||
               (((fin_r < 0) ? -32'(fin_r) : 32'(fin_r)) > TOO_FAST_LIM);
    end

    // too_fast is judged on the sample being loaded so it changes with out_vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            out_vld  <= 1'b0;
            too_fast <= 1'b0;
            tf_cnt   <= '0;
        end else begin
            out_vld <= pre_v;
            if (pre_v) begin
                lft_spd  <= fin_l;
                rght_spd <= fin_r;
                if (over != too_fast) begin
                    if (tf_cnt == 4'(TF_CNT - 1)) begin
                        too_fast <= ~too_fast;
                        tf_cnt   <= '0;
                    end else begin
                        tf_cnt <= tf_cnt + 4'd1;
                    end
                end else begin
                    tf_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_balance_cntrl_pipe.sv
// tb/tb_balance_cntrl_pipe.sv - self-checking bench for balance_cntrl_pipe with an integer reference model.
module tb_balance_cntrl_pipe;
    localparam int SPD_W    = 12;
    localparam int PIPE_STG = 2;
    localparam int TF_CNT   = 4;
    localparam int LIM      = 1536;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    logic pwr_up = 1'b0;
    logic rider_off = 1'b0;
    logic en_steer = 1'b0;
    logic signed [15:0] ptch = '0;
    logic signed [15:0] ptch_rt = '0;
    logic [11:0] steer_pot = 12'h7FF;
    logic signed [SPD_W-1:0] lft_spd;
    logic signed [SPD_W-1:0] rght_spd;
    logic too_fast;
    logic out_vld;

    balance_cntrl_pipe #(
        .SPD_W(SPD_W), .PIPE_STG(PIPE_STG), .FAST_SIM(1), .TOO_FAST_LIM(LIM), .TF_CNT(TF_CNT)
    ) dut (
        .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
        .pwr_up(pwr_up), .rider_off(rider_off), .steer_pot(steer_pot), .en_steer(en_steer),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .too_fast(too_fast), .out_vld(out_vld)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int l; int r; } exp_t;
    exp_t q[$];
    int   tfq[$];
    int   n_chk = 0, n_pass = 0, cyc = 0;
    int   m_integ, m_pid, m_ss, m_tf, m_cnt, prev_l, prev_r;
    bit   m_pend, edge_pwr;
    int   got_l, got_r, got_cyc, n_out = 0;
    int   vc, n0, n1;

    function automatic int clip(int v, int lo, int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_integ = 0; m_pid = 0; m_ss = 0; m_tf = 0; m_cnt = 0;
        prev_l = 0; prev_r = 0; m_pend = 0;
    endtask

    // One clock edge of the reference: inputs are those held during the cycle just ending.
    task automatic model_edge();
        int ps;
        edge_pwr = pwr_up;
        if (rst) begin
            model_reset();
            cyc++;
            return;
        end
        if (m_pend) begin
            int sc, so, l, r;
            sc = (m_pid * m_ss) >>> 8;
            so = (int'(steer_pot) - 2047) >>> 3;
            if (!pwr_up) begin
                l = 0; r = 0;
            end else if (en_steer) begin
                l = clip(sc + so, -2048, 2047);
                r = clip(sc - so, -2048, 2047);
            end else begin
                l = sc; r = sc;
            end
            q.push_back('{due: cyc + PIPE_STG, l: l, r: r});
        end
        ps = clip(int'(ptch), -512, 511);
        if (vld)
            m_pid = clip(5 * ps + clip(m_integ >>> 2, -2048, 2047)
                         + clip(-(int'(ptch_rt) >>> 6), -2048, 2047), -2048, 2047);
        m_pend = vld;
        if (rider_off || !pwr_up) m_integ = 0;
        else if (vld) m_integ = clip(m_integ + ps, -131072, 131071);
        m_ss = pwr_up ? ((m_ss < 255) ? m_ss + 1 : 255) : 0;
        cyc++;
    endtask

    task automatic check_outputs();
        bit ev;
        int el, er;
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("out_vld", out_vld, ev);
        if (out_vld === 1'b1) begin
            got_l = lft_spd; got_r = rght_spd; got_cyc = cyc; n_out++;
        end
        if (ev) begin
            exp_t e = q.pop_front();
            el = e.l; er = e.r;
`ifdef SPD_SLEW_EN
            if (edge_pwr) begin
                el = clip(el, prev_l - 64, prev_l + 64);
                er = clip(er, prev_r - 64, prev_r + 64);
            end
            prev_l = el; prev_r = er;
`endif
            chk("lft_spd", lft_spd, el);
            chk("rght_spd", rght_spd, er);
            if (((iabs(el) > LIM) || (iabs(er) > LIM)) != (m_tf != 0)) begin
                m_cnt++;
                if (m_cnt == TF_CNT) begin
                    m_tf = (m_tf == 0) ? 1 : 0;
                    m_cnt = 0;
                end
            end else begin
                m_cnt = 0;
            end
            tfq.push_back(int'(too_fast));
        end
        chk("too_fast", too_fast, m_tf);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic pulse_vld();
        vld = 1'b1;
        step();
        vld = 1'b0;
        repeat (4) step();
    endtask

    task automatic clear_integ();
        rider_off = 1'b1;
        step();
        rider_off = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) step();
        chk("rst_lft", lft_spd, 0);
        chk("rst_rght", rght_spd, 0);
        chk("rst_tf", too_fast, 0);
        chk("rst_ovld", out_vld, 0);
        rst = 1'b0;
        pwr_up = 1'b1;
        repeat (260) step();
        chk("ss_full", dut.ss_tmr, 255);

        ptch = 16'sd100; ptch_rt = '0; en_steer = 1'b0;
        vc = cyc;
        pulse_vld();
        chk("basic_lat", got_cyc - vc, 3);
        chk("basic_l", got_l, 498);
        chk("basic_r", got_r, 498);

        clear_integ();
        chk("integ_clr", dut.integ, 0);
        en_steer = 1'b1; steer_pot = 12'hFFF;
        pulse_vld();
        chk("steer_l", got_l, 754);
        chk("steer_r", got_r, 242);
        clear_integ();
        steer_pot = 12'h7FF;
        pulse_vld();
        chk("centre_l", got_l, 498);
        chk("centre_r", got_r, 498);

        clear_integ();
        en_steer = 1'b0; ptch = 16'sh7FFF;
        tfq.delete();
        vld = 1'b1;
        repeat (4) step();
        vld = 1'b0;
        repeat (4) step();
        chk("sat_l", got_l, 2039);
        chk("sat_cnt", tfq.size(), 4);
        chk("tf_set_3rd", tfq[2], 0);
        chk("tf_set_4th", tfq[3], 1);
        ptch = '0;
        tfq.delete();
        vld = 1'b1;
        repeat (4) step();
        vld = 1'b0;
        repeat (4) step();
        chk("tf_clr_3rd", tfq[2], 1);
        chk("tf_clr_4th", tfq[3], 0);

        n0 = n_out;
        vld = 1'b1;
        repeat (5) begin
            ptch = 16'(int'($urandom_range(0, 800)) - 400);
            step();
        end
        vld = 1'b0;
        repeat (5) step();
        chk("b2b_cnt", n_out - n0, 5);

        pwr_up = 1'b0;
        step();
        ptch = 16'sd300;
        pulse_vld();
        chk("pwr_off_l", got_l, 0);
        chk("pwr_off_r", got_r, 0);
        chk("ss_clr", dut.ss_tmr, 0);
        pwr_up = 1'b1;

        repeat (400) begin
            vld       = ($urandom_range(0, 2) == 0);
            ptch      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 600)) - 300);
            ptch_rt   = 16'($urandom);
            steer_pot = 12'($urandom);
            en_steer  = 1'($urandom_range(0, 1));
            rider_off = ($urandom_range(0, 40) == 0);
            pwr_up    = pwr_up ? ($urandom_range(0, 60) != 0) : ($urandom_range(0, 4) == 0);
            step();
        end

        vld = 1'b0; pwr_up = 1'b1; en_steer = 1'b0; ptch = 16'sd200; ptch_rt = '0;
        rider_off = 1'b1;
        repeat (10) step();
        rider_off = 1'b0;
        pulse_vld();
        chk("pre_rst_nz", (lft_spd != 0), 1);
        vld = 1'b1;
        step();
        vld = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        chk("arst_lft", lft_spd, 0);
        chk("arst_rght", rght_spd, 0);
        chk("arst_ovld", out_vld, 0);
        chk("arst_tf", too_fast, 0);
        model_reset();
        n1 = n_out;
        step();
        rst = 1'b0;
        repeat (6) step();
        chk("no_stale", n_out - n1, 0);
        vc = cyc;
        pulse_vld();
        chk("fresh_lat", got_cyc - vc, 3);
        chk("fresh_cnt", n_out - n1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
